// File: rtl/enc7to3_arb.sv
// Pending-request 7-to-3 priority encoder with a non-preemptive grant/ack handshake.
// Bit 0 has the highest priority; every grant is followed by one mandatory idle cycle.
module enc7to3_arb (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       E,
    input  logic [6:0] Req,
    input  logic       Ack,
    output logic [2:0] Code,
    output logic       Valid,
    output logic       Multi,
    output logic [6:0] Pending
);

    localparam int unsigned REQ_W  = 7;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [REQ_W-1:0]    r_pending;
    logic [REQ_W-1:0]    w_pending_nxt;
    logic [REQ_W-1:0]    w_clr;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [CODE_W-1:0]   w_low_idx;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_multi;
    logic                w_multi_nxt;

    // Index of the lowest set bit; only consulted when the vector is non-zero.
    function automatic logic [CODE_W-1:0] lowest_set(input logic [REQ_W-1:0] vec);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_code;
        w_valid_nxt   = r_valid;
        w_multi_nxt   = 1'b0;
        w_clr         = (r_valid && Ack) ? (REQ_W'(1) << r_code) : '0;
        w_low_idx     = lowest_set(r_pending);
        // New captures are OR-ed after the clear so a re-request of the acked code survives.
        w_pending_nxt = (r_pending & ~w_clr) | (E ? Req : '0);

        case (r_state)
            ST_IDLE: begin
                if (r_pending != '0) begin
                    w_code_nxt  = w_low_idx;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_code_nxt  = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                if (Ack) begin
                    w_code_nxt  = '0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_code_nxt  = '0;
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Multi is computed against the same next-cycle Pending/Code it will be seen with.
        w_multi_nxt = w_valid_nxt && ((w_pending_nxt & ~(REQ_W'(1) << w_code_nxt)) != '0);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_multi   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_code    <= w_code_nxt;
            r_valid   <= w_valid_nxt;
            r_multi   <= w_multi_nxt;
        end
    end

    assign Code    = r_code;
    assign Valid   = r_valid;
    assign Multi   = r_multi;
    assign Pending = r_pending;

endmodule

// File: tb/tb_enc7to3_arb.sv
// Directed-vector bench for enc7to3_arb; inputs change and outputs are sampled 1ns after each rising edge.
module tb_enc7to3_arb;

    logic       Clock;
    logic       Resetn;
    logic       E;
    logic [6:0] Req;
    logic       Ack;
    logic [2:0] Code;
    logic       Valid;
    logic       Multi;
    logic [6:0] Pending;

    int n_vec;
    int n_err;

    enc7to3_arb dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .E       (E),
        .Req     (Req),
        .Ack     (Ack),
        .Code    (Code),
        .Valid   (Valid),
        .Multi   (Multi),
        .Pending (Pending)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0; E = 1'b0; Req = 7'h00; Ack = 1'b0;
        #12;
        n_vec++;
        if ({Valid, Multi, Code, Pending} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state: got V=%b M=%b C=%0d P=%b want all zero", Valid, Multi, Code, Pending);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        tick();
        n_vec++;
        if (Valid !== 1'b0 || Pending !== 7'h00) begin
            n_err++;
            $display("FAIL reset_release: got V=%b P=%b want V=0 P=0", Valid, Pending);
        end
    endtask

    task automatic test_single();
        E = 1'b1; Req = 7'b0010000;
        tick();
        E = 1'b0; Req = 7'h00;
        n_vec++;
        if (Pending !== 7'b0010000 || Valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pend: got P=%b V=%b want P=0010000 V=0", Pending, Valid);
        end
        tick();
        n_vec++;
        if (Valid !== 1'b1 || Code !== 3'd4 || Multi !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant: got V=%b C=%0d M=%b want V=1 C=4 M=0", Valid, Code, Multi);
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        n_vec++;
        if (Valid !== 1'b0 || Code !== 3'd0 || Pending !== 7'h00 || Multi !== 1'b0) begin
            n_err++;
            $display("FAIL single_ack: got V=%b C=%0d P=%b M=%b want 0/0/0/0", Valid, Code, Pending, Multi);
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp_code  [3];
        logic       exp_multi [3];
        logic [6:0] exp_pend  [3];
        exp_code  = '{3'd1, 3'd2, 3'd6};
        exp_multi = '{1'b1, 1'b1, 1'b0};
        exp_pend  = '{7'b1000100, 7'b1000000, 7'b0000000};
        E = 1'b1; Req = 7'b1000110;
        tick();
        E = 1'b0; Req = 7'h00;
        n_vec++;
        if (Pending !== 7'b1000110) begin
            n_err++;
            $display("FAIL prio_pend: got P=%b want 1000110", Pending);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (Valid !== 1'b1 || Code !== exp_code[k] || Multi !== exp_multi[k]) begin
                n_err++;
                $display("FAIL prio_grant%0d: got V=%b C=%0d M=%b want V=1 C=%0d M=%b",
                         k, Valid, Code, Multi, exp_code[k], exp_multi[k]);
            end
            Ack = 1'b1;
            tick();
            Ack = 1'b0;
            n_vec++;
            if (Valid !== 1'b0 || Code !== 3'd0 || Pending !== exp_pend[k]) begin
                n_err++;
                $display("FAIL prio_idle%0d: got V=%b C=%0d P=%b want V=0 C=0 P=%b",
                         k, Valid, Code, Pending, exp_pend[k]);
            end
        end
    endtask

    task automatic test_no_preempt();
        E = 1'b1; Req = 7'b0100000;
        tick();
        E = 1'b0; Req = 7'h00;
        tick();
        n_vec++;
        if (Valid !== 1'b1 || Code !== 3'd5 || Multi !== 1'b0) begin
            n_err++;
            $display("FAIL nopre_grant: got V=%b C=%0d M=%b want V=1 C=5 M=0", Valid, Code, Multi);
        end
        E = 1'b1; Req = 7'b0000001;
        for (int k = 0; k < 4; k++) begin
            tick();
            E = 1'b0; Req = 7'h00;
            n_vec++;
            if (Valid !== 1'b1 || Code !== 3'd5 || Multi !== 1'b1 || Pending !== 7'b0100001) begin
                n_err++;
                $display("FAIL nopre_hold%0d: got V=%b C=%0d M=%b P=%b want V=1 C=5 M=1 P=0100001",
                         k, Valid, Code, Multi, Pending);
            end
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        n_vec++;
        if (Valid !== 1'b0 || Pending !== 7'b0000001) begin
            n_err++;
            $display("FAIL nopre_ack: got V=%b P=%b want V=0 P=0000001", Valid, Pending);
        end
        tick();
        n_vec++;
        if (Valid !== 1'b1 || Code !== 3'd0 || Multi !== 1'b0) begin
            n_err++;
            $display("FAIL nopre_next: got V=%b C=%0d M=%b want V=1 C=0 M=0", Valid, Code, Multi);
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        n_vec++;
        if (Valid !== 1'b0 || Pending !== 7'h00) begin
            n_err++;
            $display("FAIL nopre_drain: got V=%b P=%b want V=0 P=0", Valid, Pending);
        end
    endtask

    task automatic test_set_wins();
        E = 1'b1; Req = 7'b0001000;
        tick();
        E = 1'b0; Req = 7'h00;
        tick();
        n_vec++;
        if (Valid !== 1'b1 || Code !== 3'd3) begin
            n_err++;
            $display("FAIL setwin_grant: got V=%b C=%0d want V=1 C=3", Valid, Code);
        end
        Ack = 1'b1; E = 1'b1; Req = 7'b0001000;
        tick();
        Ack = 1'b0; E = 1'b0; Req = 7'h00;
        n_vec++;
        if (Valid !== 1'b0 || Code !== 3'd0 || Pending !== 7'b0001000) begin
            n_err++;
            $display("FAIL setwin_keep: got V=%b C=%0d P=%b want V=0 C=0 P=0001000", Valid, Code, Pending);
        end
        tick();
        n_vec++;
        if (Valid !== 1'b1 || Code !== 3'd3 || Multi !== 1'b0) begin
            n_err++;
            $display("FAIL setwin_regrant: got V=%b C=%0d M=%b want V=1 C=3 M=0", Valid, Code, Multi);
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        n_vec++;
        if (Valid !== 1'b0 || Pending !== 7'h00) begin
            n_err++;
            $display("FAIL setwin_drain: got V=%b P=%b want V=0 P=0", Valid, Pending);
        end
    endtask

    task automatic test_enable_idle_ack();
        E = 1'b0; Req = 7'b1111111;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if (Pending !== 7'h00 || Valid !== 1'b0) begin
                n_err++;
                $display("FAIL en_block%0d: got P=%b V=%b want P=0 V=0", k, Pending, Valid);
            end
        end
        Req = 7'h00; Ack = 1'b1;
        tick();
        Ack = 1'b0;
        n_vec++;
        if (Pending !== 7'h00 || Valid !== 1'b0 || Code !== 3'd0 || Multi !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ack: got P=%b V=%b C=%0d M=%b want all zero", Pending, Valid, Code, Multi);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        E = 1'b1; Req = 7'b0000100; Ack = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_v = (k % 2 == 0);
            n_vec++;
            if (Valid !== exp_v || Pending !== 7'b0000100 || Code !== (exp_v ? 3'd2 : 3'd0)) begin
                n_err++;
                $display("FAIL b2b_cyc%0d: got V=%b C=%0d P=%b want V=%b C=%0d P=0000100",
                         k, Valid, Code, Pending, exp_v, exp_v ? 2 : 0);
            end
        end
        E = 1'b0; Req = 7'h00;
        tick();
        Ack = 1'b0;
        n_vec++;
        if (Valid !== 1'b0 || Pending !== 7'h00) begin
            n_err++;
            $display("FAIL b2b_drain: got V=%b P=%b want V=0 P=0", Valid, Pending);
        end
    endtask

    task automatic test_reset_mid_grant();
        E = 1'b1; Req = 7'b0100100;
        tick();
        E = 1'b0; Req = 7'h00;
        tick();
        n_vec++;
        if (Valid !== 1'b1 || Code !== 3'd2 || Multi !== 1'b1 || Pending !== 7'b0100100) begin
            n_err++;
            $display("FAIL rst_pre: got V=%b C=%0d M=%b P=%b want V=1 C=2 M=1 P=0100100",
                     Valid, Code, Multi, Pending);
        end
        #2 Resetn = 1'b0;
        #1;
        n_vec++;
        if (Valid !== 1'b0 || Code !== 3'd0 || Pending !== 7'h00 || Multi !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async: got V=%b C=%0d P=%b M=%b want all zero", Valid, Code, Pending, Multi);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        tick();
        tick();
        n_vec++;
        if (Valid !== 1'b0 || Pending !== 7'h00) begin
            n_err++;
            $display("FAIL rst_after: got V=%b P=%b want V=0 P=0", Valid, Pending);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_set_wins();
        test_enable_idle_ack();
        test_back_to_back();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/enc7to3_arb.md
ENC7TO3_ARB -- requirements
Module: enc7to3_arb

Interface
REQ-001 No parameters; request width fixed at 7, code width fixed at 3.
REQ-002 One clock; reset is asynchronous and active-low: Clock and Resetn.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Resetn  input  1  asynchronous active-low reset.
REQ-005 E  input  1  capture enable; Req sampled only when E=1.
REQ-006 Req  input  7  request lines, bit i requests code i; multi-hot legal.
REQ-007 Ack  input  1  consumer accepts current Code.
REQ-008 Code  output  3  binary index of granted request, 0..6.
REQ-009 Valid  output  1  Code holds a live grant.
REQ-010 Multi  output  1  other requests still pending besides the granted one.
REQ-011 Pending  output  7  registered pending-request vector.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 Pending SHALL update each edge: Pending_next = (Pending & ~clr) | (E ? Req : 7'b0), where clr is the one-hot of Code when Valid=1 and Ack=1, else 0.
REQ-014 Set SHALL win over clear: a Req bit equal to the acked code, with E=1 in the ack cycle, remains pending.
REQ-015 FSM SHALL have two states, IDLE and GRANT; reset state IDLE.
REQ-016 IDLE: if Pending != 0, next edge loads Code = index of lowest set Pending bit (bit 0 highest priority), Valid=1, go GRANT; else stay, Valid=0.
REQ-017 GRANT: Code SHALL be held stable while Ack=0, regardless of new higher-priority requests (no preemption).
REQ-018 GRANT with Ack=1: next edge Valid=0, Code=3'b000, Multi=0, go IDLE.
REQ-019 Ack while Valid=0 SHALL be ignored; Pending unchanged by it.
REQ-020 Latency: Req bit with E=1 at edge N, FSM idle, Pending empty -> Pending set after edge N, Valid=1 with Code after edge N+1 (2 cycles).
REQ-021 Back-to-back throughput: at most one grant per 2 cycles (mandatory IDLE cycle after each ack).
REQ-022 Multi SHALL be 1 exactly when Valid=1 and Pending has a set bit other than bit Code; registered with Valid and Code and updated each cycle in GRANT.
REQ-023 Code SHALL never take value 3'b111; Code=3'b000 whenever Valid=0.
REQ-024 E=0 SHALL block new captures only; already-pending requests are still granted and acked normally.
REQ-025 Requests held high with E=1 across multiple cycles SHALL re-pend after their ack (level-sensitive capture, no edge detection).

Reset
REQ-026 Resetn=0 SHALL asynchronously force state IDLE, Pending=7'b0, Code=3'b000, Valid=0, Multi=0.
REQ-027 Reset asserted mid-grant SHALL drop Valid immediately and discard all pending requests; first grant after release requires fresh Req with E=1.
REQ-028 Resetn deassertion SHALL be synchronized to Clock by the integrator; block takes no action on the release edge itself beyond leaving reset.

Verification
REQ-029 Single: reset, E=1, Req=7'b0010000 one cycle -> Pending=7'b0010000 next cycle, then Valid=1, Code=3'b100, Multi=0; Ack=1 -> Valid=0, Pending=0.
REQ-030 Priority: E=1, Req=7'b1000110 one cycle -> grants in order Code=1 (Multi=1), Code=2 (Multi=1), Code=6 (Multi=0), one per Ack, IDLE cycle between each.
REQ-031 No preemption/stability: grant Code=5 held, Ack=0 for 4 cycles while Req=7'b0000001 pulsed -> Code stays 5; after Ack next grant Code=0.
REQ-032 Set-wins: in Ack cycle for Code=3, E=1, Req=7'b0001000 -> Pending[3] stays 1, Code=3 re-granted after IDLE cycle.
REQ-033 Enable/idle Ack: E=0, Req=7'b1111111 -> Pending stays 0, Valid stays 0; Ack pulses with Valid=0 -> no state change.
REQ-034 Reset mid-grant: Valid=1, Code=2, Pending=7'b0100100, Resetn=0 between edges -> Valid=0, Code=0, Pending=0 immediately, before next Clock edge.
